iref_bank_seq: RTL and testbench
================================

Name: iref_bank_seq

Overview:
Multi-channel successor to the single current-reference model. Sequences power-up, calibration settling and ready signalling for N_CH independent bias-current references from one clock, with a cycle-count settle time instead of a fixed delay. Optional serial mode arbitrates so that only one channel calibrates at a time. Sits between the top-level power sequencer and the analog bias consumers. The sequencer consumes RDY_IREF, ALL_RDY and the pulse outputs.

Parameters:
N_CH, 4, number of reference channels (1..16)
SETTLE_CYC, 900, calibration settle time in CLK cycles (>=2); 900 = 9 us at 100 MHz
SERIAL, 0, 0 = channels calibrate concurrently; 1 = at most one channel in CAL at a time, lowest index wins
Derived: CNT_W = clog2(SETTLE_CYC+1), per-channel counter width.

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  synchronous active-high reset
PU_IREF  input  N_CH  per-channel power-up level; 0 forces the channel off
CAL_IREF  input  N_CH  per-channel calibration request level
RDY_IREF  output  N_CH  channel calibrated and ready, registered
CAL_BUSY  output  N_CH  channel in CAL state, registered
CAL_DONE  output  N_CH  1-cycle pulse, same cycle RDY_IREF rises
CAL_ABORT  output  N_CH  1-cycle pulse when a calibration is abandoned
ALL_RDY  output  1  AND of RDY_IREF, combinational from registers

Behaviour:
- Reset: all channels IDLE, counters 0, RDY_IREF/CAL_BUSY/CAL_DONE/CAL_ABORT = 0, ALL_RDY = 0. RST has priority over every input.
- Per-channel FSM, states IDLE, CAL, READY. Priority order: RST, then PU low, then the transitions below.
- Any state with PU_IREF[i]=0 -> IDLE, counter cleared, RDY_IREF[i]/CAL_BUSY[i] low after that edge.
- PU low in CAL: also pulse CAL_ABORT[i].
- IDLE, PU&CAL high, granted -> CAL, counter <= 1, CAL_BUSY high.
- CAL, PU&CAL high, counter < SETTLE_CYC -> counter +1.
- CAL, PU&CAL high, counter = SETTLE_CYC -> READY: RDY_IREF high, CAL_BUSY low, CAL_DONE pulse, counter cleared.
- CAL, PU high, CAL low -> IDLE, CAL_ABORT pulse, counter cleared.
- READY: CAL_IREF ignored; stays until PU low or RST. Recalibration requires a PU drop.
- Latency: CAL&PU first sampled at edge E0 (granted) -> RDY_IREF high after edge E0+SETTLE_CYC. Total: SETTLE_CYC cycles of CAL_BUSY, then RDY.
- CAL & PU asserted on the same edge from IDLE is legal; no separate power-up cycle is required.
- SERIAL=0: grant always true.
- SERIAL=1 grant rules:
  - Grant is evaluated on current registered state.
  - Channel i is granted iff no channel is in CAL, and i is the lowest-index channel in IDLE with PU&CAL high.
  - Ungranted requesters remain IDLE with CAL_BUSY low. Nothing is latched; the request must still be held when granted.
  - A channel leaving CAL at edge k (done or abort) frees the grant from edge k+1. No channel enters CAL at edge k.
- CAL_DONE and CAL_ABORT are never high together for a channel. Pulses last exactly one cycle.
- Counter never exceeds SETTLE_CYC; no wrap.
- Channels otherwise fully independent: no cross-channel effect except the SERIAL grant.

Test Plan:
- N_CH=4, SETTLE_CYC=8, SERIAL=0, RST 3 cycles then released, inputs 0 -> all outputs 0 through and after reset.
- PU_IREF=4'b0001 and CAL_IREF=4'b0001 at edge E0 -> CAL_BUSY[0] high after E0 for 8 cycles. RDY_IREF[0] and CAL_DONE[0] high after E0+8; CAL_DONE low after E0+9; ALL_RDY stays 0.
- PU=4'b1111, CAL=4'b1111, all channels concurrent -> all RDY high after E0+8, ALL_RDY=1. Drop PU[2] -> RDY[2]=0 and ALL_RDY=0 after the next edge; no CAL_ABORT.
- CAL[1] dropped after 4 CAL cycles -> CAL_ABORT[1] 1-cycle pulse, back to IDLE, RDY[1] never rises. Re-raise CAL[1] -> full 8 cycles again.
- SERIAL=1, PU=CAL=4'b1010 at E0 -> ch1 CAL over E0..E0+8, READY at E0+8. Ch3 enters CAL at edge E0+9, RDY[3] after E0+17. Never two CAL_BUSY bits high at once.
- RST asserted mid-CAL (counter=5) -> next edge all outputs 0, no CAL_ABORT pulse. After RST release with PU/CAL held -> restart, RDY 8 cycles later.

Source files
------------

// File: rtl/iref_bank_seq_if.sv
// rtl/iref_bank_seq_if.sv - bus grouping for the multi-channel current-reference sequencer
//
// Purpose: carries the per-channel request levels and the registered
// status/pulse outputs of iref_bank_seq.
// Signals:
//   PU_IREF   [N_CH] power-up level per channel (master -> slave)
//   CAL_IREF  [N_CH] calibration request level per channel (master -> slave)
//   RDY_IREF  [N_CH] channel calibrated and ready (slave -> master)
//   CAL_BUSY  [N_CH] channel calibrating (slave -> master)
//   CAL_DONE  [N_CH] one-cycle pulse as RDY_IREF rises (slave -> master)
//   CAL_ABORT [N_CH] one-cycle pulse when a calibration is abandoned (slave -> master)
//   ALL_RDY          every channel ready (slave -> master)
interface iref_bank_seq_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] PU_IREF;
  logic [N_CH-1:0] CAL_IREF;
  logic [N_CH-1:0] RDY_IREF;
  logic [N_CH-1:0] CAL_BUSY;
  logic [N_CH-1:0] CAL_DONE;
  logic [N_CH-1:0] CAL_ABORT;
  logic            ALL_RDY;

  modport master (
    output PU_IREF,
    output CAL_IREF,
    input  RDY_IREF,
    input  CAL_BUSY,
    input  CAL_DONE,
    input  CAL_ABORT,
    input  ALL_RDY
  );

  modport slave (
    input  PU_IREF,
    input  CAL_IREF,
    output RDY_IREF,
    output CAL_BUSY,
    output CAL_DONE,
    output CAL_ABORT,
    output ALL_RDY
  );
endinterface

// File: rtl/iref_bank_seq.sv
// rtl/iref_bank_seq.sv - power-up / calibration / ready sequencer for N_CH current references
//
// Purpose: each channel runs an IDLE -> CAL -> READY state machine. A channel
// spends exactly SETTLE_CYC cycles in CAL before it reports ready. With
// SERIAL=1 at most one channel calibrates at a time; the lowest-index idle
// requester wins once no channel is calibrating.
// Ports:
//   CLK  clock, all state changes on the rising edge
//   RST  synchronous active-high reset, overrides every input
//   bus  iref_bank_seq_if slave modport (requests in, status/pulses out)
module iref_bank_seq #(
  parameter int N_CH       = 4,
  parameter int SETTLE_CYC = 900,
  parameter int SERIAL     = 0
) (
  input  logic           CLK,
  input  logic           RST,
  iref_bank_seq_if.slave bus
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAL   = 2'd1,
    READY = 2'd2
  } state_t;

  state_t           st_q  [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]  rdy_q;
  logic [N_CH-1:0]  busy_q;
  logic [N_CH-1:0]  done_q;
  logic [N_CH-1:0]  abort_q;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  grant;
  logic             found;

  assign req = bus.PU_IREF & bus.CAL_IREF;

  // busy_q is high exactly while a channel sits in CAL, so it doubles as the
  // "someone is calibrating" flag. Because it is registered, a channel that
  // leaves CAL on edge k still blocks the grant at edge k.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (SERIAL == 0) begin
        grant[i] = 1'b1;
      end else if (!found && (busy_q == '0) && (st_q[i] == IDLE) && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
      rdy_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      abort_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        done_q[i]  <= 1'b0;
        abort_q[i] <= 1'b0;
        if (!bus.PU_IREF[i]) begin
          // Power removal wins over any request; only a live calibration aborts.
          if (st_q[i] == CAL) begin
            abort_q[i] <= 1'b1;
          end
          st_q[i]   <= IDLE;
          cnt_q[i]  <= '0;
          rdy_q[i]  <= 1'b0;
          busy_q[i] <= 1'b0;
        end else begin
          case (st_q[i])
            IDLE: begin
              if (bus.CAL_IREF[i] && grant[i]) begin
                st_q[i]   <= CAL;
                cnt_q[i]  <= CNT_W'(1);
                busy_q[i] <= 1'b1;
              end
            end
            CAL: begin
              if (!bus.CAL_IREF[i]) begin
                st_q[i]    <= IDLE;
                cnt_q[i]   <= '0;
                busy_q[i]  <= 1'b0;
                abort_q[i] <= 1'b1;
              end else if (cnt_q[i] == SETTLE_V) begin
                st_q[i]   <= READY;
                cnt_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                rdy_q[i]  <= 1'b1;
                done_q[i] <= 1'b1;
              end else begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
              end
            end
            READY: begin
              // Calibration requests are ignored until power is dropped.
            end
            default: begin
              st_q[i]   <= IDLE;
              cnt_q[i]  <= '0;
              rdy_q[i]  <= 1'b0;
              busy_q[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.RDY_IREF  = rdy_q;
  assign bus.CAL_BUSY  = busy_q;
  assign bus.CAL_DONE  = done_q;
  assign bus.CAL_ABORT = abort_q;
  assign bus.ALL_RDY   = &rdy_q;

endmodule

// File: tb/tb_iref_bank_seq.sv
// tb/tb_iref_bank_seq.sv - scoreboard bench for iref_bank_seq (concurrent and serial instances)
module tb_iref_bank_seq;

  typedef struct packed {
    logic [3:0] rdy;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] abort;
    logic       all;
  } exp_t;

  logic  clk;
  logic  rst;
  int    tests;
  int    fails;
  string phase;
  exp_t  q0[$];
  exp_t  q1[$];

  iref_bank_seq_if #(.N_CH(4)) if0 ();
  iref_bank_seq_if #(.N_CH(4)) if1 ();

  iref_bank_seq #(.N_CH(4), .SETTLE_CYC(8), .SERIAL(0)) dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (if0)
  );

  iref_bank_seq #(.N_CH(4), .SETTLE_CYC(8), .SERIAL(1)) dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [3:0] rdy, input logic [3:0] busy,
                              input logic [3:0] done, input logic [3:0] abort,
                              input logic all);
    exp_t e;
    e.rdy   = rdy;
    e.busy  = busy;
    e.done  = done;
    e.abort = abort;
    e.all   = all;
    return e;
  endfunction

  // Inputs are applied at the falling edge; the expectation describes the
  // outputs after the following rising edge.
  task automatic step0(input logic r, input logic [3:0] pu, input logic [3:0] cal, input exp_t e);
    @(negedge clk);
    rst          = r;
    if0.PU_IREF  = pu;
    if0.CAL_IREF = cal;
    q0.push_back(e);
  endtask

  task automatic step1(input logic r, input logic [3:0] pu, input logic [3:0] cal, input exp_t e);
    @(negedge clk);
    rst          = r;
    if1.PU_IREF  = pu;
    if1.CAL_IREF = cal;
    q1.push_back(e);
  endtask

  task automatic rep0(input int n, input logic r, input logic [3:0] pu, input logic [3:0] cal, input exp_t e);
    for (int k = 0; k < n; k++) step0(r, pu, cal, e);
  endtask

  task automatic rep1(input int n, input logic r, input logic [3:0] pu, input logic [3:0] cal, input exp_t e);
    for (int k = 0; k < n; k++) step1(r, pu, cal, e);
  endtask

  // Monitor: pops one expectation per DUT per cycle and compares.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e   = q0.pop_front();
        got = mk(if0.RDY_IREF, if0.CAL_BUSY, if0.CAL_DONE, if0.CAL_ABORT, if0.ALL_RDY);
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL dut0 %s: got rdy=%b busy=%b done=%b abort=%b all=%b, want rdy=%b busy=%b done=%b abort=%b all=%b",
                   phase, got.rdy, got.busy, got.done, got.abort, got.all,
                   e.rdy, e.busy, e.done, e.abort, e.all);
        end
      end
      if (q1.size() > 0) begin
        e   = q1.pop_front();
        got = mk(if1.RDY_IREF, if1.CAL_BUSY, if1.CAL_DONE, if1.CAL_ABORT, if1.ALL_RDY);
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL dut1 %s: got rdy=%b busy=%b done=%b abort=%b all=%b, want rdy=%b busy=%b done=%b abort=%b all=%b",
                   phase, got.rdy, got.busy, got.done, got.abort, got.all,
                   e.rdy, e.busy, e.done, e.abort, e.all);
        end
      end
      tests++;
      if ($countones(if1.CAL_BUSY) > 1) begin
        fails++;
        $display("FAIL serial_single_cal: got busy=%b, want at most one bit set", if1.CAL_BUSY);
      end
    end
  end

  initial begin
    exp_t z;
    tests = 0;
    fails = 0;
    z     = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst   = 1'b1;
    if0.PU_IREF  = '0;
    if0.CAL_IREF = '0;
    if1.PU_IREF  = '0;
    if1.CAL_IREF = '0;

    phase = "reset";
    rep0(3, 1'b1, 4'b0000, 4'b0000, z);
    phase = "idle_after_reset";
    rep0(2, 1'b0, 4'b0000, 4'b0000, z);

    phase = "single_ch0";
    rep0(8, 1'b0, 4'b0001, 4'b0001, mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0001, 4'b0001, mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0));
    rep0(2, 1'b0, 4'b0001, 4'b0001, mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    phase = "single_ch0_off";
    step0(1'b0, 4'b0000, 4'b0000, z);

    phase = "all_concurrent";
    rep0(8, 1'b0, 4'b1111, 4'b1111, mk(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b1111, 4'b1111, mk(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1));
    step0(1'b0, 4'b1111, 4'b1111, mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b1));
    phase = "drop_pu2";
    step0(1'b0, 4'b1011, 4'b1111, mk(4'b1011, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0000, 4'b0000, z);

    phase = "abort_by_cal";
    rep0(4, 1'b0, 4'b0010, 4'b0010, mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0010, 4'b0000, mk(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0));
    step0(1'b0, 4'b0010, 4'b0000, z);
    phase = "recal_ch1";
    rep0(8, 1'b0, 4'b0010, 4'b0010, mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0010, 4'b0010, mk(4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0));
    step0(1'b0, 4'b0010, 4'b0010, mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0000, 4'b0000, z);

    phase = "abort_by_pu";
    rep0(2, 1'b0, 4'b0001, 4'b0001, mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0000, 4'b0001, mk(4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0));
    step0(1'b0, 4'b0000, 4'b0000, z);

    phase = "rst_mid_cal";
    rep0(5, 1'b0, 4'b0001, 4'b0001, mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    rep0(2, 1'b1, 4'b0001, 4'b0001, z);
    phase = "rst_restart";
    rep0(8, 1'b0, 4'b0001, 4'b0001, mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0001, 4'b0001, mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0));
    step0(1'b0, 4'b0001, 4'b0001, mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    step0(1'b0, 4'b0000, 4'b0000, z);

    phase = "serial_1010";
    rep1(8, 1'b0, 4'b1010, 4'b1010, mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0));
    step1(1'b0, 4'b1010, 4'b1010, mk(4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0));
    rep1(8, 1'b0, 4'b1010, 4'b1010, mk(4'b0010, 4'b1000, 4'b0000, 4'b0000, 1'b0));
    step1(1'b0, 4'b1010, 4'b1010, mk(4'b1010, 4'b0000, 4'b1000, 4'b0000, 1'b0));
    step1(1'b0, 4'b1010, 4'b1010, mk(4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0));
    step1(1'b0, 4'b0000, 4'b0000, z);

    phase = "serial_lowest_wins";
    rep1(8, 1'b0, 4'b0011, 4'b0011, mk(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0));
    step1(1'b0, 4'b0011, 4'b0011, mk(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0));
    rep1(8, 1'b0, 4'b0011, 4'b0011, mk(4'b0001, 4'b0010, 4'b0000, 4'b0000, 1'b0));
    step1(1'b0, 4'b0011, 4'b0011, mk(4'b0011, 4'b0000, 4'b0010, 4'b0000, 1'b0));
    step1(1'b0, 4'b0000, 4'b0000, z);

    repeat (3) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
